// File: rtl/sevenseg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus.
// Each stable one-hot-low anode interval yields exactly one capture.
module sevenseg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segment,
    input  logic [7:0] an,
    input  logic       clear,
    input  logic [2:0] rd_sel,
    output logic [3:0] rd_num,
    output logic       rd_valid,
    output logic       rd_err,
    output logic       frame_done,
    output logic       timeout
);

    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_CAP  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [14:0]   s_cur_q, s_prev_q, cap_q, cap_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    digit_q [8];
    logic [3:0]    digit_d [8];
    logic [7:0]    valid_q, valid_d, err_q, err_d, seen_q, seen_d;
    logic          frame_q, frame_d, tout_q, tout_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic       changed, one_hot, do_cap, legal;
    logic [2:0] idx;
    logic [3:0] nib;
    logic [7:0] cap_an;
    logic [6:0] cap_seg;

    assign changed = (s_cur_q != s_prev_q);
    assign one_hot = $onehot(~s_cur_q[14:7]);
    assign do_cap  = (state_q == ST_CAP);
    assign cap_an  = cap_q[14:7];
    assign cap_seg = cap_q[6:0];

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!cap_an[i]) idx = 3'(i);
        end
    end

    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (cap_seg)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        scnt_d = changed ? '0 : ((scnt_q == SMAX) ? SMAX : scnt_q + SW'(1));
        state_d = state_q;
        cap_d   = cap_q;
        // Decide on the pre-edge bus value and latch it, so a change
        // landing on the capture edge cannot corrupt the stored digit.
        case (state_q)
            ST_WAIT: begin
                if (scnt_d == SMAX && one_hot) begin
                    state_d = ST_CAP;
                    cap_d   = s_cur_q;
                end
            end
            ST_CAP:  state_d = changed ? ST_WAIT : ST_HOLD;
            ST_HOLD: state_d = changed ? ST_WAIT : ST_HOLD;
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        digit_d = digit_q;
        valid_d = clear ? 8'h00 : valid_q;
        err_d   = clear ? 8'h00 : err_q;
        seen_d  = (clear || seen_q == 8'hFF) ? 8'h00 : seen_q;
        frame_d = (seen_q == 8'hFF) && !clear;
        if (do_cap) begin
            digit_d[idx] = legal ? nib : 4'h0;
            valid_d[idx] = 1'b1;
            err_d[idx]   = !legal;
            seen_d[idx]  = 1'b1;
        end
        if (do_cap || clear) tcnt_d = '0;
        else if (tcnt_q == TMAX) tcnt_d = TMAX;
        else tcnt_d = tcnt_q + TW'(1);
        tout_d = clear ? 1'b0 : (tout_q || tcnt_d == TMAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_cur_q  <= 15'h7FFF;
            s_prev_q <= 15'h7FFF;
            cap_q    <= 15'h7FFF;
            scnt_q   <= '0;
            state_q  <= ST_WAIT;
            for (int i = 0; i < 8; i++) digit_q[i] <= 4'h0;
            valid_q  <= 8'h00;
            err_q    <= 8'h00;
            seen_q   <= 8'h00;
            frame_q  <= 1'b0;
            tcnt_q   <= '0;
            tout_q   <= 1'b0;
        end else begin
            s_cur_q  <= {an, segment};
            s_prev_q <= s_cur_q;
            cap_q    <= cap_d;
            scnt_q   <= scnt_d;
            state_q  <= state_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            tcnt_q   <= tcnt_d;
            tout_q   <= tout_d;
        end
    end

    assign rd_num     = digit_q[rd_sel];
    assign rd_valid   = valid_q[rd_sel];
    assign rd_err     = err_q[rd_sel];
    assign frame_done = frame_q;
    assign timeout    = tout_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scenarios plus randomized
// scans checked against a run-length based digit/frame/timeout model.
module tb_sevenseg_scan_decoder;

    localparam int S = 4;
    localparam int T = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] segment = 7'h7F;
    logic [7:0] an = 8'hFF;
    logic       clear = 1'b0;
    logic [2:0] rd_sel = 3'd0;
    logic [3:0] rd_num;
    logic       rd_valid, rd_err, frame_done, timeout;

    sevenseg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .segment(segment), .an(an),
        .clear(clear), .rd_sel(rd_sel), .rd_num(rd_num),
        .rd_valid(rd_valid), .rd_err(rd_err),
        .frame_done(frame_done), .timeout(timeout)
    );

    always #10 clk = ~clk;

    logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

    logic [3:0]  m_num [8];
    logic        m_valid [8];
    logic        m_err [8];
    logic [7:0]  m_seen;
    logic [14:0] m_last;
    int m_run, m_since, m_frames, frames_obs;
    int total = 0, bad = 0;

    always @(negedge clk) if (frame_done === 1'b1) frames_obs++;

    function automatic void dec(input logic [6:0] s, output logic ok,
                                output logic [3:0] n);
        ok = 1'b0;
        n = 4'h0;
        for (int i = 0; i < 16; i++)
            if (CODES[i] == s) begin ok = 1'b1; n = 4'(i); end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_num[i] = 4'h0; m_valid[i] = 1'b0; m_err[i] = 1'b0;
        end
        m_seen = 8'h00;
        m_last = 15'h7FFF;
        m_run = 0;
        m_since = 0;
    endtask

    // One clock with the given bus value; a capture happens once per
    // unchanged run that reaches S clocks with exactly one anode low.
    task automatic step(input logic [7:0] a, input logic [6:0] s,
                        input logic c);
        logic ok;
        logic [3:0] n;
        int idx;
        an = a; segment = s; clear = c;
        @(posedge clk);
        if ({a, s} == m_last) m_run++;
        else begin m_last = {a, s}; m_run = 1; end
        m_since++;
        if (c) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 1'b0; m_err[i] = 1'b0;
            end
            m_seen = 8'h00;
            m_since = 0;
        end
        if (m_run == S && $countones(a) == 7) begin
            idx = 0;
            for (int i = 0; i < 8; i++) if (!a[i]) idx = i;
            dec(s, ok, n);
            m_num[idx] = n;
            m_valid[idx] = 1'b1;
            m_err[idx] = !ok;
            m_seen[idx] = 1'b1;
            if (m_seen == 8'hFF) begin m_frames++; m_seen = 8'h00; end
            m_since = 0;
        end
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] s,
                        input int n);
        for (int k = 0; k < n; k++) step(a, s, 1'b0);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            total++;
            if (rd_valid !== m_valid[i]) begin
                bad++;
                $display("FAIL %s rd_valid[%0d] got %b want %b",
                         tag, i, rd_valid, m_valid[i]);
            end
            total++;
            if (rd_num !== m_num[i] || rd_err !== m_err[i]) begin
                bad++;
                $display("FAIL %s digit[%0d] got num=%h err=%b want num=%h err=%b",
                         tag, i, rd_num, rd_err, m_num[i], m_err[i]);
            end
        end
        total++;
        if (frames_obs !== m_frames) begin
            bad++;
            $display("FAIL %s frame_count got %0d want %0d",
                     tag, frames_obs, m_frames);
        end
        if (m_since < T - 5 || m_since > T + 5) begin
            total++;
            if (timeout !== (m_since > T + 5)) begin
                bad++;
                $display("FAIL %s timeout got %b want %b",
                         tag, timeout, m_since > T + 5);
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        m_frames = 0;
        frames_obs = 0;
        repeat (3) @(negedge clk);
        check_all("reset_held");
        reset = 1'b1;
        @(negedge clk);
        check_all("reset_release");
    endtask

    task automatic test_blank();
        hold(8'hFF, 7'h7F, 20);
        check_all("blank");
    endtask

    task automatic test_single();
        hold(8'hFE, 7'h12, S + 2);
        check_all("single_d0");
        hold(8'hFE, 7'h12, 50);
        check_all("single_hold");
    endtask

    task automatic test_frame();
        logic [7:0] a;
        for (int d = 0; d < 8; d++) begin
            a = ~(8'h01 << d);
            if (d == 7) check_all("frame_pre7");
            hold(a, CODES[d], 8);
        end
        check_all("frame_scan");
    endtask

    task automatic test_unstable_illegal();
        step(8'hFF, 7'h7F, 1'b1);
        check_all("clear1");
        for (int k = 0; k < 15; k++)
            hold(8'hFB, (k % 2 == 0) ? 7'h24 : 7'h30, 2);
        check_all("toggle_d2");
        hold(8'hF7, 7'h55, 8);
        check_all("illegal_d3");
    endtask

    task automatic test_ghost_timeout();
        hold(8'hFC, 7'h00, 10);
        check_all("ghost");
        hold(8'hFC, 7'h00, T + 20);
        check_all("timeout_set");
        hold(8'hFC, 7'h00, 20);
        check_all("timeout_sticky");
        step(8'hFC, 7'h00, 1'b1);
        check_all("timeout_clear");
        hold(8'hFC, 7'h00, 3);
        check_all("after_clear");
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [6:0] s;
        int kind;
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 99);
            if (kind < 5) begin
                step(8'hFF, 7'h7F, 1'b1);
            end else begin
                do begin
                    if (kind < 75 || kind >= 90) begin
                        a = ~(8'h01 << $urandom_range(0, 7));
                    end else begin
                        do a = 8'($urandom);
                        while ($countones(a) > 6 && a != 8'hFF);
                    end
                    if ($urandom_range(0, 4) == 0) s = 7'($urandom);
                    else s = CODES[$urandom_range(0, 15)];
                end while ({a, s} == m_last);
                if (kind >= 90) hold(a, s, $urandom_range(1, 2));
                else hold(a, s, $urandom_range(S + 3, S + 6));
            end
            check_all("random");
        end
    endtask

    task automatic test_reset_mid();
        hold(8'hBF, 7'h0E, 3);
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (frame_done !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid flags got frame=%b tout=%b want 0 0",
                     frame_done, timeout);
        end
        check_all("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hold(8'hBF, 7'h0E, 8);
        check_all("rst_recover");
    endtask

    initial begin
        test_reset();
        test_blank();
        test_single();
        test_frame();
        test_unstable_illegal();
        test_ghost_timeout();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receive-side counterpart of the 8-digit multiplexed seven-segment display controller.
- Watches the time-multiplexed segment/anode bus, waits for each pattern to stay stable, and decodes it back to a hex nibble per digit.
- Keeps the 8 recovered digits in a readable register file, with per-digit valid/error flags, a frame-complete pulse and a scan-timeout flag.
- Used as a readback/self-check block beside the display driver.

Parameters:
STABLE_CYCLES, 4, consecutive clocks an/segment must hold unchanged before capture (>=2)
TIMEOUT_CYCLES, 1024, clocks without any capture before timeout asserts

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
segment  input  7  active-low segments, bit0=a ... bit6=g
an  input  8  active-low anodes, bit i = digit i
clear  input  1  sync; clears valid, err, seen mask and timeout
rd_sel  input  3  digit index to read
rd_num  output  4  decoded nibble of digit rd_sel (combinational read)
rd_valid  output  1  digit rd_sel captured since last clear/reset
rd_err  output  1  last capture of digit rd_sel was an illegal pattern
frame_done  output  1  one-cycle pulse when all 8 digits are captured in the current frame
timeout  output  1  sticky; no capture for TIMEOUT_CYCLES clocks

Behaviour:
- Reset (reset=0, async):
  - digit regs = 0; valid, err and seen masks = 0
  - frame_done = 0, timeout = 0
  - stable counter and timeout counter = 0; FSM = WAIT
- Input stage: {an,segment} registered every clock into s_cur; the previous value is held in s_prev.
- Stable counter:
  - Cleared to 0 when s_cur != s_prev.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- FSM:
  - WAIT -> CAPTURE when the counter reaches STABLE_CYCLES-1 and s_cur.an is exactly one-hot-low.
  - CAPTURE, a single cycle:
    - writes digit idx = index of the zero bit in an
    - sets valid[idx] and seen[idx]
    - goes to HOLD
  - HOLD -> WAIT on any change of s_cur, so each stable interval produces exactly one capture.
- Latency: inputs changed before edge k and held constant give an updated rd_num/rd_valid after edge k+STABLE_CYCLES+1.
- Decode table (segment hex -> nibble), all other codes illegal:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
  - Legal code: err[idx] cleared.
  - Illegal code: nibble stored as 0, err[idx] set, valid[idx] still set.
- No capture when:
  - an=FF (blanking)
  - more than one an bit is low (ghosting)
  - the pattern does not hold for STABLE_CYCLES
  - These cases are ignored silently.
- Frame:
  - When the seen mask becomes FF, frame_done pulses for one cycle on the next clock and seen clears.
  - Recapturing an already-seen digit overwrites its value and does not advance the frame.
- Timeout:
  - The counter increments every clock and is cleared on each CAPTURE.
  - When it reaches TIMEOUT_CYCLES, timeout=1 and the counter saturates.
  - timeout is cleared only by clear or reset.
- clear in the same cycle as CAPTURE: the captured digit's valid/seen bits end up set; all other flags clear. Digit values are never cleared by clear.
- Reset asserted mid-interval: the pending capture is discarded and no partial write occurs.
- rd_num, rd_valid and rd_err follow rd_sel combinationally; out-of-range reads are not possible (3-bit index).

Test Plan:
1. Reset then release, an=FF, segment=7F for 20 clocks -> rd_valid=0 for all rd_sel, frame_done never pulses, rd_num=0.
2. an=FE, segment=12 held 6 clocks -> after edge STABLE_CYCLES+1, rd_sel=0 gives rd_num=5, rd_valid=1, rd_err=0; holding another 50 clocks produces no second capture.
3. Scan digits 0..7 with an=FE,FD,...,7F and codes 40,79,24,30,19,12,02,78, each held 8 clocks -> rd_num 0..7 per index, exactly one frame_done pulse after digit 7.
4. an=FB with segment toggling 24/30 every 2 clocks for 30 clocks -> no capture for digit 2. Then an=F7, segment=55 (illegal) held 8 clocks -> rd_sel=3 gives rd_valid=1, rd_err=1, rd_num=0.
5. Multi-low an=FC, segment=00 held 10 clocks -> no capture. Then no input change for TIMEOUT_CYCLES clocks -> timeout=1, stays 1 until clear; clear -> timeout=0 and all valid=0, with digit values retained.
6. Pull reset low 2 clocks into a stable an=BF/segment=0E interval -> all flags 0 immediately. After release, holding 8 more clocks captures digit 6 = F.
